// File: rtl/cart_fetch_pkg.sv
// Shared types and constants for the cartridge ROM read-fetch stage.
package cart_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam logic [7:0] UNMAPPED_DATA = 8'hFF;
    localparam int unsigned ADDR_W = 25;

endpackage

// File: rtl/cart_rom_fetch.sv
// SDRAM read-fetch stage behind the cartridge mapper: one read per CPU access,
// one-entry last-byte cache, and a timeout that returns FFh.
module cart_rom_fetch
    import cart_fetch_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic              cpu_mreq,
    input  logic              cpu_rd,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_unmaped,
    input  logic [ADDR_W-1:0] rom_base,
    input  logic              flush,
    output logic              sdram_req,
    output logic [ADDR_W-1:0] sdram_addr,
    input  logic              sdram_ack,
    input  logic [7:0]        sdram_dout,
    output logic              cpu_wait,
    output logic [7:0]        dout
);

    localparam int unsigned     CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    fetch_state_t      state_q;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        dout_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] base_q;
    logic              cache_valid_q;
    logic [ADDR_W-1:0] cache_addr_q;
    logic [7:0]        cache_data_q;
    logic              inval_seen_q;

    logic              sel;
    logic              start;
    logic              invalidate;
    logic              hit;
    logic [ADDR_W-1:0] addr_sum;

    assign sel        = cs & ~mem_unmaped;
    assign start      = (state_q == IDLE) & sel & cpu_mreq & cpu_rd;
    assign addr_sum   = rom_base + mem_addr;
    assign invalidate = flush | (rom_base != base_q);
    // Invalidation in the start cycle must already defeat the hit.
    assign hit        = cache_valid_q & ~invalidate & (cache_addr_q == addr_sum);

    assign sdram_req  = req_q;
    assign sdram_addr = addr_q;
    assign cpu_wait   = (start & ~hit) | (state_q == REQ);
    assign dout       = sel ? dout_q : UNMAPPED_DATA;

    always_ff @(posedge clk) begin
        base_q <= rom_base;
        if (reset) begin
            state_q       <= IDLE;
            req_q         <= 1'b0;
            addr_q        <= '0;
            dout_q        <= UNMAPPED_DATA;
            cnt_q         <= '0;
            cache_valid_q <= 1'b0;
            cache_addr_q  <= '0;
            cache_data_q  <= '0;
            inval_seen_q  <= 1'b0;
        end else begin
            if (invalidate) begin
                cache_valid_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (hit) begin
                            dout_q  <= cache_data_q;
                            state_q <= HOLD;
                        end else begin
                            addr_q       <= addr_sum;
                            cnt_q        <= '0;
                            inval_seen_q <= 1'b0;
                            req_q        <= 1'b1;
                            state_q      <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (invalidate) begin
                        inval_seen_q <= 1'b1;
                    end
                    // Ack beats a simultaneous timeout; a flush seen at any point
                    // of the fetch keeps its byte out of the cache.
                    if (sdram_ack) begin
                        dout_q       <= sdram_dout;
                        cache_addr_q <= addr_q;
                        cache_data_q <= sdram_dout;
                        if (!invalidate && !inval_seen_q) begin
                            cache_valid_q <= 1'b1;
                        end
                        req_q   <= 1'b0;
                        state_q <= HOLD;
                    end else if (cnt_q == CNT_LAST) begin
                        dout_q  <= UNMAPPED_DATA;
                        req_q   <= 1'b0;
                        state_q <= HOLD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (!cpu_mreq) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cart_rom_fetch.sv
// Randomized bench for cart_rom_fetch against a transaction-level cache model.
module tb_cart_rom_fetch;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs;
    logic        cpu_mreq;
    logic        cpu_rd;
    logic [24:0] mem_addr;
    logic        mem_unmaped;
    logic [24:0] rom_base;
    logic        flush;
    logic        sdram_req;
    logic [24:0] sdram_addr;
    logic        sdram_ack;
    logic [7:0]  sdram_dout;
    logic        cpu_wait;
    logic [7:0]  dout;

    int total = 0;
    int bad   = 0;

    // Model of the last-byte cache: what the CPU should observe per access.
    bit          m_valid;
    logic [24:0] m_addr;
    logic [7:0]  m_data;
    logic [24:0] m_base;

    always #5 clk = ~clk;

    cart_rom_fetch #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .cs(cs), .cpu_mreq(cpu_mreq), .cpu_rd(cpu_rd),
        .mem_addr(mem_addr), .mem_unmaped(mem_unmaped), .rom_base(rom_base),
        .flush(flush), .sdram_req(sdram_req), .sdram_addr(sdram_addr),
        .sdram_ack(sdram_ack), .sdram_dout(sdram_dout), .cpu_wait(cpu_wait),
        .dout(dout)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // One complete CPU read access; ack_at=0 means never acked,
    // flush_at/drop_at = -1 means no flush pulse / no early cpu_mreq drop.
    task automatic run_read(input logic [24:0] base, input logic [24:0] addr,
                            input int ack_at, input logic [7:0] data,
                            input int flush_at, input int drop_at, input string tag);
        logic [24:0] exp_addr;
        logic [7:0]  exp_d;
        bit          hit;
        bit          acked;
        bit          flushed;
        bit          dropped;
        int          fin;
        exp_addr = 25'((longint'(base) + longint'(addr)) % (longint'(1) << 25));
        if (base != m_base) m_valid = 0;
        m_base = base;
        if (flush_at == 0) m_valid = 0;
        hit = m_valid && (m_addr == exp_addr);

        next_cycle();
        rom_base = base; mem_addr = addr; cs = 1; mem_unmaped = 0;
        cpu_mreq = 1; cpu_rd = 1; flush = (flush_at == 0); sdram_ack = 0;
        sample();
        total++;
        if (cpu_wait !== !hit) begin
            bad++; $display("FAIL %s wait_c0 got=%b exp=%b", tag, cpu_wait, !hit);
        end
        total++;
        if (sdram_req !== 1'b0) begin
            bad++; $display("FAIL %s req_c0 got=%b exp=0", tag, sdram_req);
        end

        if (hit) begin
            exp_d = m_data;
            for (int c = 1; c <= 2; c++) begin
                next_cycle();
                flush = 0;
                sample();
                total++;
                if (sdram_req !== 1'b0 || cpu_wait !== 1'b0 || dout !== exp_d) begin
                    bad++;
                    $display("FAIL %s hit c=%0d req=%b wait=%b dout=%h exp req=0 wait=0 dout=%h",
                             tag, c, sdram_req, cpu_wait, dout, exp_d);
                end
            end
        end else begin
            acked   = (ack_at >= 1) && (ack_at <= int'(TO));
            fin     = acked ? ack_at : int'(TO);
            flushed = (flush_at >= 1) && (flush_at <= fin);
            dropped = (drop_at >= 1) && (drop_at <= fin);
            for (int c = 1; c <= fin; c++) begin
                next_cycle();
                flush      = (c == flush_at);
                sdram_ack  = (c == ack_at);
                sdram_dout = (c == ack_at) ? data : 8'($urandom);
                if (c == drop_at) begin
                    cpu_mreq = 0; cpu_rd = 0;
                end
                sample();
                total++;
                if (sdram_req !== 1'b1 || cpu_wait !== 1'b1) begin
                    bad++;
                    $display("FAIL %s miss c=%0d req=%b wait=%b exp req=1 wait=1",
                             tag, c, sdram_req, cpu_wait);
                end
                if (c == 1) begin
                    total++;
                    if (sdram_addr !== exp_addr) begin
                        bad++;
                        $display("FAIL %s addr got=%h exp=%h", tag, sdram_addr, exp_addr);
                    end
                end
            end
            exp_d = acked ? data : 8'hFF;
            if (flushed) m_valid = 0;
            if (acked && !flushed) begin
                m_valid = 1; m_addr = exp_addr; m_data = data;
            end
            next_cycle();
            flush = 0;
            sdram_ack  = !acked;          // a stray ack after timeout must be ignored
            sdram_dout = 8'h5A;
            sample();
            total++;
            if (sdram_req !== 1'b0 || cpu_wait !== 1'b0 || dout !== exp_d) begin
                bad++;
                $display("FAIL %s done req=%b wait=%b dout=%h exp req=0 wait=0 dout=%h",
                         tag, sdram_req, cpu_wait, dout, exp_d);
            end
            if (!dropped) begin
                next_cycle();
                sdram_ack = 0;
                sample();
                total++;
                if (sdram_req !== 1'b0 || dout !== exp_d) begin
                    bad++;
                    $display("FAIL %s hold req=%b dout=%h exp req=0 dout=%h",
                             tag, sdram_req, dout, exp_d);
                end
            end
        end

        next_cycle();
        cpu_mreq = 0; cpu_rd = 0; sdram_ack = 0; flush = 0;
        sample();
        total++;
        if (cpu_wait !== 1'b0 || sdram_req !== 1'b0) begin
            bad++;
            $display("FAIL %s release wait=%b req=%b exp 0 0", tag, cpu_wait, sdram_req);
        end
    endtask

    task automatic test_reset();
        reset = 1; cs = 1; mem_unmaped = 0; cpu_mreq = 0; cpu_rd = 0;
        mem_addr = '0; rom_base = 25'h100000; flush = 0; sdram_ack = 0; sdram_dout = '0;
        repeat (3) next_cycle();
        reset = 0;
        sample();
        total++;
        if (sdram_req !== 1'b0 || cpu_wait !== 1'b0 || dout !== 8'hFF || sdram_addr !== 25'h0) begin
            bad++;
            $display("FAIL reset req=%b wait=%b dout=%h addr=%h exp 0 0 ff 0",
                     sdram_req, cpu_wait, dout, sdram_addr);
        end
        m_valid = 0; m_base = 25'h100000;
    endtask

    task automatic test_miss_hit_inval();
        run_read(25'h100000, 25'h02000, 5, 8'hA5, -1, -1, "miss");
        run_read(25'h100000, 25'h02000, 3, 8'h00, -1, -1, "hit");
        run_read(25'h000000, 25'h02000, 4, 8'h6B, -1, -1, "base_change");
        run_read(25'h000000, 25'h02000, 2, 8'hC7,  0, -1, "flush_start");
        run_read(25'h000000, 25'h02000, 2, 8'h00, -1, -1, "hit_after_flush");
    endtask

    task automatic test_unmapped();
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            cs = (k == 0); mem_unmaped = (k == 0);
            cpu_mreq = 1; cpu_rd = 1; mem_addr = 25'h02000;
            for (int c = 0; c < 3; c++) begin
                sample();
                total++;
                if (dout !== 8'hFF || sdram_req !== 1'b0 || cpu_wait !== 1'b0) begin
                    bad++;
                    $display("FAIL unmapped k=%0d c=%0d dout=%h req=%b wait=%b exp ff 0 0",
                             k, c, dout, sdram_req, cpu_wait);
                end
                next_cycle();
            end
            cpu_mreq = 0; cpu_rd = 0; cs = 1; mem_unmaped = 0;
        end
        next_cycle();
    endtask

    task automatic test_timeout();
        run_read(25'h000000, 25'h00777, 0, 8'h00, -1, -1, "timeout");
        run_read(25'h000000, 25'h00777, 2, 8'h19, -1, -1, "after_timeout");
    endtask

    task automatic test_reset_mid_req();
        next_cycle();
        rom_base = 25'h0; mem_addr = 25'h03000; cs = 1; mem_unmaped = 0;
        cpu_mreq = 1; cpu_rd = 1;
        sample();
        for (int c = 1; c <= 2; c++) next_cycle();
        next_cycle();
        reset = 1; cpu_mreq = 0; cpu_rd = 0;
        sample();
        total++;
        if (sdram_req !== 1'b1) begin
            bad++; $display("FAIL rst_mid req_c3 got=%b exp=1", sdram_req);
        end
        next_cycle();
        reset = 0; sdram_ack = 1; sdram_dout = 8'h77;
        sample();
        total++;
        if (sdram_req !== 1'b0 || cpu_wait !== 1'b0 || dout !== 8'hFF) begin
            bad++;
            $display("FAIL rst_mid after req=%b wait=%b dout=%h exp 0 0 ff", sdram_req, cpu_wait, dout);
        end
        next_cycle();
        sdram_ack = 0;
        sample();
        total++;
        if (sdram_req !== 1'b0 || dout !== 8'hFF) begin
            bad++; $display("FAIL rst_mid late req=%b dout=%h exp 0 ff", sdram_req, dout);
        end
        m_valid = 0;
        run_read(25'h000000, 25'h03000, 3, 8'h2E, -1, -1, "after_rst");
    endtask

    task automatic test_edges();
        run_read(25'h000000, 25'h04444, int'(TO), 8'h3C, -1, -1, "ack_at_timeout");
        run_read(25'h000000, 25'h04444, 1, 8'h00, -1, -1, "ack_at_timeout_hit");
        run_read(25'h000000, 25'h05555, 6, 8'h9E, -1, 2, "mreq_drop");
        run_read(25'h000000, 25'h05555, 1, 8'h00, -1, -1, "mreq_drop_hit");
        run_read(25'h000000, 25'h06666, 4, 8'h42, 2, -1, "flush_in_req");
        run_read(25'h000000, 25'h06666, 3, 8'h43, -1, -1, "flush_in_req_again");
        run_read(25'h1FFFF00, 25'h00200, 3, 8'h81, -1, -1, "wrap");
    endtask

    task automatic test_random();
        logic [24:0] bases [3];
        logic [24:0] addrs [4];
        int fa;
        int da;
        bases[0] = 25'h100000; bases[1] = 25'h000000; bases[2] = 25'h1FFFF80;
        addrs[0] = 25'h02000;  addrs[1] = 25'h00080;  addrs[2] = 25'h1FFFFFF; addrs[3] = 25'h12345;
        for (int i = 0; i < 40; i++) begin
            fa = ($urandom % 8 == 0) ? 0 : (($urandom % 8 == 1) ? int'($urandom_range(1, 4)) : -1);
            da = ($urandom % 6 == 0) ? int'($urandom_range(1, 3)) : -1;
            run_read((i % 5 == 4) ? bases[$urandom % 3] : m_base, addrs[$urandom % 4],
                     int'($urandom_range(1, 20)), 8'($urandom), fa, da, "random");
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_miss_hit_inval();
        test_unmapped();
        test_timeout();
        test_reset_mid_req();
        test_edges();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cart_rom_fetch.md
# cart_rom_fetch

Read-fetch stage directly downstream of the cartridge mapper. Takes the mapper's translated cartridge address and unmapped flag, adds the cartridge's SDRAM base offset, and issues one SDRAM read per CPU memory-read access. While the read is outstanding it stalls the CPU through `cpu_wait`, then returns the byte on `dout`. A one-entry last-byte cache skips the SDRAM for repeated reads of the same address, and a timeout returns `FFh` if the SDRAM never answers.

## Interface
- `TIMEOUT`, 255: cycles `sdram_req` may stay high before the fetch is aborted (1..1023).
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `cs` in 1: cartridge slot selected.
- `cpu_mreq` in 1: CPU memory request, active-high.
- `cpu_rd` in 1: CPU read strobe, active-high.
- `mem_addr` in 25: mapper-translated cartridge address.
- `mem_unmaped` in 1: the mapper flags the current address as outside the ROM.
- `rom_base` in 25: SDRAM offset of this cartridge image.
- `flush` in 1: invalidates the cache (asserted on image reload).
- `sdram_req` out 1: read request, level-held until ack.
- `sdram_addr` out 25: read address, `rom_base + mem_addr` modulo 2^25.
- `sdram_ack` in 1: single-cycle pulse; `sdram_dout` is valid in the same cycle.
- `sdram_dout` in 8: read data.
- `cpu_wait` out 1: stall the CPU, active-high.
- `dout` out 8: read data to the CPU bus.

## Operation
- **Access start (`start`).** `cs & cpu_mreq & cpu_rd & ~mem_unmaped` while the state is IDLE.
  - Only one fetch is made per access.
  - A new access can start only after `cpu_mreq` has fallen.
- **Unmapped or deselected.** If `cs & ~mem_unmaped` is false, `dout = FFh` combinationally, with no request and no wait.
- **State IDLE.**
  - Hit = cache valid and `cache_addr == sdram_addr`.
  - On `start` with a hit: load `dout_r` from the cache and go to HOLD. `cpu_wait` is never asserted.
  - On `start` with a miss: register `sdram_addr`, clear the timeout counter and go to REQ.
- **State REQ.** `sdram_req = 1`; the counter increments every cycle.
  - On `sdram_ack`: `dout_r = sdram_dout`, `cache_addr`/`cache_data` are updated, the cache is marked valid, and the state goes to HOLD.
  - When the counter reaches `TIMEOUT - 1` without an ack: `dout_r = FFh`, the cache is unchanged, and the state goes to HOLD.
- **State HOLD.** `dout_r` is held. Return to IDLE in the first cycle in which `cpu_mreq = 0`.
- **`dout` when selected and mapped.** `dout = dout_r`.
- **Cache invalidation.** The valid bit clears on reset, on `flush`, or on any change of `rom_base` (compared against a registered copy).

## Timing
- **Reset values.** `sdram_req = 0`, `sdram_addr = 0`, `cpu_wait = 0`, `dout_r = FFh`, state IDLE, cache invalid, counter 0.
- **Wait generation.** `cpu_wait = (IDLE & start & ~hit) | REQ`.
  - It is asserted combinationally in the start cycle (cycle 0).
  - It is held through the ack cycle N and is low from cycle N+1.
- **Miss latency.** `sdram_req` rises in cycle 1 and falls in the cycle after the ack. `dout` is valid from cycle N+1.
- **Hit latency.** `dout` is valid from cycle 1; there are zero wait cycles.
- **Ack and timeout in the same cycle.** The ack wins: its data is used and cached.
- **Stray acks.** `sdram_ack` is ignored in IDLE and HOLD.
- **Flush or base change during a hit-start cycle.** Invalidation takes priority, so the access is treated as a miss.
- **Flush during REQ.** The result is not cached.
- **`cpu_mreq` falls during REQ.** The fetch completes; the state passes through HOLD for one cycle, then returns to IDLE.
- **Reset mid-fetch.** The state returns to IDLE and `sdram_req` drops in the next cycle. A late ack is ignored.
- **Address arithmetic.** The 25-bit add wraps silently; no carry out.

## Structure
- Package `cart_fetch_pkg`:
  - state enum `fetch_state_t` (IDLE, REQ, HOLD);
  - localparam `UNMAPPED_DATA = 8'hFF`.
- Single module with no sub-modules. The cache is two registers plus a valid bit, inline.
- The counter width is derived as `$clog2(TIMEOUT+1)`.

## Test plan
- **Miss.**
  - Stimulus: `rom_base = 0x100000`, `mem_addr = 0x02000`, read; ack after 5 cycles with `A5h`.
  - Expected:
    - `sdram_addr = 0x102000`;
    - `cpu_wait` high for cycles 0..5;
    - `dout = A5h` from cycle 6;
    - exactly one request.
- **Hit.** Repeat the same read.
  - Expected: no `sdram_req`, `cpu_wait` never high, `dout = A5h`.
- **Invalidation.** Change `rom_base` to `0x000000` (or pulse `flush`), then repeat the read.
  - Expected: a miss is issued, with `sdram_addr = 0x002000`.
- **Unmapped.** Read with `mem_unmaped = 1`.
  - Expected: `dout = FFh`, no request, no wait.
- **Timeout.** Leave ack low with `TIMEOUT = 16`.
  - Expected: `sdram_req` high for 16 cycles, then `dout = FFh`; the next read of the same address misses again.
- **Reset mid-REQ.** Assert reset in cycle 3, then send a late ack.
  - Expected: the late ack is ignored, `cpu_wait = 0`, `dout = FFh`.
- **Ack equals timeout.** Ack arrives in the expiry cycle with data `3Ch`.
  - Expected: `dout = 3Ch` and the byte is cached.
